// File: rtl/if_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// if_fetch_unit_if
//   Groups the signals of the instruction-fetch unit: the PC register link,
//   the instruction-memory read handshake and the valid/ready link to ID.
//
//   pc_in      current PC from the PC register
//   pc_en      PC register load enable
//   flush      redirect from branch/jump resolution
//   mem_req    instruction memory read request
//   mem_addr   word-aligned read address
//   mem_ack    memory returns data this cycle
//   mem_rdata  instruction word (valid with mem_ack)
//   id_valid   head entry available to ID
//   id_ready   ID consumes the head entry
//   id_pc      PC of the head entry
//   id_instr   instruction of the head entry
//   id_adel    head entry came from a misaligned PC
//
//   master: the fetch unit; slave: its surroundings (PC reg, memory, ID).
// ---------------------------------------------------------------------------
interface if_fetch_unit_if;
    logic [31:0] pc_in;
    logic        pc_en;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        id_adel;

    modport master (
        input  pc_in, flush, mem_ack, mem_rdata, id_ready,
        output pc_en, mem_req, mem_addr, id_valid, id_pc, id_instr, id_adel
    );

    modport slave (
        output pc_in, flush, mem_ack, mem_rdata, id_ready,
        input  pc_en, mem_req, mem_addr, id_valid, id_pc, id_instr, id_adel
    );
endinterface

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//   Instruction-fetch reader. Reads the instruction at the PC register's
//   current value over a variable-latency req/ack memory handshake, buffers
//   {pc, instr, adel} in a DEPTH-entry FIFO and presents the head entry to
//   the ID stage over valid/ready. Drives the PC register's load enable so
//   the PC advances only on an accepted fetch or a flush.
//
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    if_fetch_unit_if.master (PC link, memory handshake, ID link)
// ---------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          DEPTH    = 2
) (
    input  logic             clk,
    input  logic             reset,
    if_fetch_unit_if.master  bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [31:0]        addr_q;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;

    logic [31:0]        pc_mem    [DEPTH];
    logic [31:0]        instr_mem [DEPTH];
    logic               adel_mem  [DEPTH];

    logic               not_full;
    logic               push, pop, latch, accept, mem_req_c;
    logic [31:0]        push_pc, push_instr;
    logic               push_adel;
    logic               valid;

    assign not_full = (count < CNT_W'(DEPTH));
    assign valid    = (count != '0);
    assign pop      = valid && bus.id_ready;

    always_comb begin
        state_nxt  = state;
        push       = 1'b0;
        push_pc    = addr_q;
        push_instr = bus.mem_rdata;
        push_adel  = 1'b0;
        latch      = 1'b0;
        accept     = 1'b0;
        mem_req_c  = 1'b0;
        case (state)
            IDLE: begin
                if (!bus.flush && not_full) begin
                    if (bus.pc_in[1:0] == 2'b00) begin
                        latch     = 1'b1;
                        state_nxt = REQ;
                    end else begin
                        // Misaligned PC: no memory access, queue an
                        // address-error entry and step past it.
                        push       = 1'b1;
                        push_pc    = bus.pc_in;
                        push_instr = '0;
                        push_adel  = 1'b1;
                        accept     = 1'b1;
                    end
                end
            end
            REQ: begin
                mem_req_c = 1'b1;
                if (bus.mem_ack && !bus.flush) begin
                    push      = 1'b1;
                    accept    = 1'b1;
                    state_nxt = IDLE;
                end else if (bus.flush) begin
                    // Redirected: an already-returning word is dropped now,
                    // otherwise the in-flight read must still be drained.
                    state_nxt = bus.mem_ack ? IDLE : DISCARD;
                end
            end
            DISCARD: begin
                mem_req_c = 1'b1;
                if (bus.mem_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.mem_req  = mem_req_c;
    assign bus.mem_addr = addr_q;
    assign bus.pc_en    = accept || bus.flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            addr_q <= RESET_PC;
        end else begin
            state <= state_nxt;
            if (latch) begin
                addr_q <= bus.pc_in;
            end
        end
    end

    // FIFO control: flush empties the queue and overrides push/pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage: data only, validity is carried by count.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= push_pc;
            instr_mem[wr_ptr] <= push_instr;
            adel_mem[wr_ptr]  <= push_adel;
        end
    end

    assign bus.id_valid = valid;
    assign bus.id_pc    = valid ? pc_mem[rd_ptr]    : '0;
    assign bus.id_instr = valid ? instr_mem[rd_ptr] : '0;
    assign bus.id_adel  = valid && adel_mem[rd_ptr];

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit
//   Bench for if_fetch_unit: a cycle table of directed vectors, a reset
//   corner sequence and a randomized run with a PC register, a variable
//   latency memory and an in-order ID consumer around the design.
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    if_fetch_unit_if bus();

    if_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    typedef struct {
        logic        flush;
        logic        ack;
        logic        ready;
        logic [31:0] rdata;
        logic [31:0] pc;
        logic        req;
        logic [31:0] addr;
        logic        pc_en;
        logic        valid;
        logic [31:0] id_pc;
        logic [31:0] id_instr;
        logic        adel;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic fl, input logic ak, input logic rd,
                                input logic [31:0] rdat, input logic [31:0] pc,
                                input logic rq, input logic [31:0] ad, input logic pe,
                                input logic vl, input logic [31:0] ipc,
                                input logic [31:0] ins, input logic ae);
        vec_t v;
        v.flush = fl; v.ack = ak; v.ready = rd; v.rdata = rdat; v.pc = pc;
        v.req = rq; v.addr = ad; v.pc_en = pe; v.valid = vl;
        v.id_pc = ipc; v.id_instr = ins; v.adel = ae;
        return v;
    endfunction

    task automatic drive_idle(input logic [31:0] pc);
        bus.pc_in     = pc;
        bus.flush     = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        bus.id_ready  = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_req"},  {31'b0, bus.mem_req},  32'd0);
        check({tag, "_mem_addr"}, bus.mem_addr,          RESET_PC);
        check({tag, "_pc_en"},    {31'b0, bus.pc_en},    32'd0);
        check({tag, "_id_valid"}, {31'b0, bus.id_valid}, 32'd0);
        check({tag, "_id_pc"},    bus.id_pc,             32'd0);
        check({tag, "_id_instr"}, bus.id_instr,          32'd0);
        check({tag, "_id_adel"},  {31'b0, bus.id_adel},  32'd0);
    endtask

    // Environment state for the randomized run.
    logic [31:0] pc_reg, exp_next, addr0, tgt;
    logic        busy, ack, fl, post_flush;
    int          lat, waited, pops;

    initial begin
        reset = 1'b1;
        drive_idle(RESET_PC);

        // Directed cycle table: test-plan items 1-5.
        tbl.push_back(mk(0,0,0,32'h0,        32'h3000, 1,32'h3000,0, 0,32'h0,   32'h0,        0));
        tbl.push_back(mk(0,1,0,32'h3C01_0001,32'h3000, 1,32'h3000,1, 0,32'h0,   32'h0,        0));
        tbl.push_back(mk(0,0,0,32'h0,        32'h3004, 0,32'h3000,0, 1,32'h3000,32'h3C01_0001,0));
        tbl.push_back(mk(0,1,0,32'h2002_0004,32'h3004, 1,32'h3004,1, 1,32'h3000,32'h3C01_0001,0));
        tbl.push_back(mk(0,0,0,32'h0,        32'h3008, 0,32'h3004,0, 1,32'h3000,32'h3C01_0001,0));
        tbl.push_back(mk(0,0,1,32'h0,        32'h3008, 0,32'h3004,0, 1,32'h3000,32'h3C01_0001,0));
        tbl.push_back(mk(0,0,0,32'h0,        32'h3008, 0,32'h3004,0, 1,32'h3004,32'h2002_0004,0));
        tbl.push_back(mk(0,0,0,32'h0,        32'h3008, 1,32'h3008,0, 1,32'h3004,32'h2002_0004,0));
        tbl.push_back(mk(1,0,0,32'h0,        32'h3008, 1,32'h3008,1, 1,32'h3004,32'h2002_0004,0));
        tbl.push_back(mk(0,0,0,32'h0,        32'h3100, 1,32'h3008,0, 0,32'h0,   32'h0,        0));
        tbl.push_back(mk(0,1,0,32'hDEAD_BEEF,32'h3100, 1,32'h3008,0, 0,32'h0,   32'h0,        0));
        tbl.push_back(mk(0,0,0,32'h0,        32'h3100, 0,32'h3008,0, 0,32'h0,   32'h0,        0));
        tbl.push_back(mk(0,1,0,32'h1111_0003,32'h3100, 1,32'h3100,1, 0,32'h0,   32'h0,        0));
        tbl.push_back(mk(0,0,0,32'h0,        32'h3104, 0,32'h3100,0, 1,32'h3100,32'h1111_0003,0));
        tbl.push_back(mk(1,1,1,32'hBADC_0DE0,32'h3104, 1,32'h3104,1, 1,32'h3100,32'h1111_0003,0));
        tbl.push_back(mk(0,0,0,32'h0,        32'h3200, 0,32'h3104,0, 0,32'h0,   32'h0,        0));
        tbl.push_back(mk(0,0,0,32'h0,        32'h3200, 1,32'h3200,0, 0,32'h0,   32'h0,        0));
        tbl.push_back(mk(0,1,0,32'h4444_0004,32'h3200, 1,32'h3200,1, 0,32'h0,   32'h0,        0));
        tbl.push_back(mk(0,0,1,32'h0,        32'h3002, 0,32'h3200,1, 1,32'h3200,32'h4444_0004,0));
        tbl.push_back(mk(0,0,0,32'h0,        32'h3008, 0,32'h3200,0, 1,32'h3002,32'h0,        1));
        tbl.push_back(mk(0,0,0,32'h0,        32'h3008, 1,32'h3008,0, 1,32'h3002,32'h0,        1));

        repeat (2) @(posedge clk);
        #2;
        check_reset_outputs("reset_hold");
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk);
            #1;
            bus.flush     = tbl[i].flush;
            bus.mem_ack   = tbl[i].ack;
            bus.mem_rdata = tbl[i].rdata;
            bus.id_ready  = tbl[i].ready;
            bus.pc_in     = tbl[i].pc;
            #1;
            check($sformatf("row%0d_mem_req", i),  {31'b0, bus.mem_req},  {31'b0, tbl[i].req});
            check($sformatf("row%0d_mem_addr", i), bus.mem_addr,          tbl[i].addr);
            check($sformatf("row%0d_pc_en", i),    {31'b0, bus.pc_en},    {31'b0, tbl[i].pc_en});
            check($sformatf("row%0d_id_valid", i), {31'b0, bus.id_valid}, {31'b0, tbl[i].valid});
            check($sformatf("row%0d_id_pc", i),    bus.id_pc,             tbl[i].id_pc);
            check($sformatf("row%0d_id_instr", i), bus.id_instr,          tbl[i].id_instr);
            check($sformatf("row%0d_id_adel", i),  {31'b0, bus.id_adel},  {31'b0, tbl[i].adel});
        end

        // Reset in the middle of a request, then a stray ack.
        #1;
        reset = 1'b1;
        drive_idle(RESET_PC);
        #1;
        check_reset_outputs("mid_req_reset");
        @(posedge clk);
        #1;
        reset         = 1'b0;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hFACE_0BAD;
        #1;
        check("stray_ack_pc_en",    {31'b0, bus.pc_en},    32'd0);
        check("stray_ack_id_valid", {31'b0, bus.id_valid}, 32'd0);
        @(posedge clk);
        #1;
        bus.mem_ack = 1'b0;
        #1;
        check("after_stray_id_valid", {31'b0, bus.id_valid}, 32'd0);
        check("after_stray_mem_req",  {31'b0, bus.mem_req},  32'd1);
        check("after_stray_mem_addr", bus.mem_addr,          RESET_PC);
        @(posedge clk);
        #1;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h0000_0055;
        #1;
        check("refetch_pc_en", {31'b0, bus.pc_en}, 32'd1);
        @(posedge clk);
        #1;
        bus.mem_ack = 1'b0;
        #1;
        check("refetch_id_valid", {31'b0, bus.id_valid}, 32'd1);
        check("refetch_id_pc",    bus.id_pc,             RESET_PC);
        check("refetch_id_instr", bus.id_instr,          32'h0000_0055);

        // Randomized run against the environment model.
        #1;
        reset = 1'b1;
        drive_idle(RESET_PC);
        repeat (2) @(posedge clk);
        #1;
        reset      = 1'b0;
        pc_reg     = RESET_PC;
        exp_next   = RESET_PC;
        busy       = 1'b0;
        post_flush = 1'b0;
        lat        = 0;
        waited     = 0;
        pops       = 0;
        addr0      = 32'h0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk);
            #1;
            bus.pc_in = pc_reg;
            ack = 1'b0;
            if (bus.mem_req) begin
                if (!busy) begin
                    busy   = 1'b1;
                    lat    = $urandom_range(0, 3);
                    waited = 0;
                    addr0  = bus.mem_addr;
                    check("rand_addr_aligned", {30'b0, bus.mem_addr[1:0]}, 32'd0);
                end else begin
                    check("rand_addr_stable", bus.mem_addr, addr0);
                end
                if (waited == lat) begin
                    ack  = 1'b1;
                    busy = 1'b0;
                end else begin
                    waited++;
                end
            end
            bus.mem_ack   = ack;
            bus.mem_rdata = ack ? mem_word(bus.mem_addr) : $urandom;
            fl  = ($urandom_range(0, 15) == 0);
            tgt = 32'h3000 + ($urandom_range(0, 1023) << 2)
                  + (($urandom_range(0, 7) == 0) ? 32'd2 : 32'd0);
            bus.flush    = fl;
            bus.id_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (post_flush) begin
                check("rand_valid_after_flush", {31'b0, bus.id_valid}, 32'd0);
            end
            if (fl) begin
                check("rand_pc_en_on_flush", {31'b0, bus.pc_en}, 32'd1);
                exp_next = tgt;
            end else if (bus.id_valid && bus.id_ready) begin
                check("rand_id_pc",   bus.id_pc, exp_next);
                check("rand_id_adel", {31'b0, bus.id_adel},
                      {31'b0, (exp_next[1:0] != 2'b00)});
                check("rand_id_instr", bus.id_instr,
                      (exp_next[1:0] != 2'b00) ? 32'h0 : mem_word(exp_next));
                exp_next = exp_next + 32'd4;
                pops++;
            end
            if (bus.pc_en) begin
                pc_reg = fl ? tgt : pc_reg + 32'd4;
            end
            post_flush = fl;
        end
        check("rand_progress", {31'b0, (pops >= 100)}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch reader on the consumer side of the PC register. It takes the current fetch address from the PC register and reads the instruction memory over a req/ack handshake that allows variable latency. Fetched {pc, instr} pairs are buffered in a small FIFO and handed to the ID stage over a valid/ready interface. It also drives the PC register's load enable, so the PC advances only when a fetch has been accepted or a redirect (flush) occurs.

Parameters:
RESET_PC  32'h0000_3000  fetch address used after reset; must match the PC register's reset value
DEPTH  2  FIFO entries (power of two, ≥2)

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high; clears all state immediately
pc_in  in  32  current PC from the PC register
pc_en  out  1  load enable for the PC register (PC<=NPC when 1)
flush  in  1  redirect from branch/jump resolution; NPC mux selects the target this cycle
mem_req  out  1  instruction memory read request
mem_addr  out  32  read address, word aligned
mem_ack  in  1  memory returns data this cycle
mem_rdata  in  32  instruction word, valid when mem_ack=1
id_valid  out  1  ID-stage entry available
id_ready  in  1  ID stage consumes the head entry
id_pc  out  32  PC of head entry
id_instr  out  32  instruction of head entry
id_adel  out  1  head entry came from a misaligned PC (pc[1:0]!=0); id_instr=0

Behaviour:
- Reset (async): state=IDLE, FIFO empty, mem_req=0, mem_addr=RESET_PC, pc_en=0, id_valid=0, id_pc=0, id_instr=0, id_adel=0. A reset during an outstanding request abandons that request; any later mem_ack is ignored until a new request is issued.
- States: IDLE, REQ, DISCARD.
- IDLE: if !flush and count<DEPTH: if pc_in[1:0]==0, latch mem_addr<=pc_in, go to REQ. Otherwise push {pc_in, 32'h0, adel=1} and pulse pc_en=1, staying in IDLE with no memory request. If FIFO is full, wait.
- REQ: mem_req=1, and mem_addr is held stable until ack. Only one request is outstanding at a time.
  - mem_ack & !flush: push {mem_addr, mem_rdata, adel=0}, pc_en=1 this cycle, go to IDLE.
  - flush & !mem_ack: go to DISCARD.
  - flush & mem_ack: drop the data and go to IDLE.
- DISCARD: mem_req stays 1 until mem_ack. On ack, drop the data, leave pc_en=0, go to IDLE. A further flush while in DISCARD stays in DISCARD and asserts pc_en=1.
- pc_en = accepted fetch (as above) OR flush. A flush always loads the PC with the redirect target in that same cycle.
- Fetch latency: at least 1 cycle in IDLE plus the memory latency. With a zero-wait memory (ack in the first REQ cycle), the sustained rate is one instruction every 2 cycles.
- FIFO: id_valid = count!=0; the id_* outputs show the head entry. A pop happens on id_valid & id_ready.
  - Push and pop in the same cycle leaves count unchanged.
  - Pointers wrap modulo DEPTH.
  - Push when full cannot happen, because requests are gated by count<DEPTH.
- flush clears the FIFO (count=0) at the same edge and takes precedence over a pop and any push that cycle. id_valid is 0 the cycle after a flush.
- Instructions reach ID in PC order; none is duplicated or lost without a flush.

Test Plan:
1. Reset release, memory acks after 1 cycle returning 32'h3C01_0001 for 0x3000 → mem_addr=0x3000, pc_en pulses once, id_valid=1 with id_pc=0x3000 and id_instr=32'h3C01_0001.
2. id_ready=0, stream from 0x3000 → two entries (0x3000, 0x3004) buffered, then mem_req stays 0. After one pop, the request for 0x3008 is issued on the next IDLE cycle.
3. Flush while in REQ (ack 3 cycles late), target 0x3100 → late data is dropped, pc_en=1 on the flush cycle only, the next request goes to 0x3100 and the FIFO is empty.
4. Flush in the same cycle as mem_ack with id_ready=1 and 1 entry queued → entry is not popped to ID, ack data is dropped, count=0, next fetch goes to the target.
5. pc_in=0x3002 → no mem_req, entry {0x3002, 0, adel=1} is pushed, pc_en=1.
6. Assert reset mid-REQ, then a stray mem_ack → outputs are at reset values immediately, and the stray ack causes no push.
